// File: rtl/apple_placer.sv
// ----------------------------------------------------------------------------
// apple_placer
//
// Game-side master of the apple generator. Watches the snake head for an eat,
// asks the generator for a new apple position, and checks every candidate
// against the head and each body segment before publishing it as valid.
//
// Ports
//   clk_25M       in   system clock
//   rst           in   asynchronous, active-low reset
//   move_tick     in   1-cycle pulse: head_x/head_y just updated
//   head_x/head_y in   snake head position
//   snake_len     in   number of body segments held in body RAM
//   body_rd_addr  out  body RAM read address
//   body_x/body_y in   body RAM read data, one cycle after body_rd_addr
//   apple_x_pos/
//   apple_y_pos   in   candidate position from the generator
//   apple_gen     out  1-cycle request for a new candidate
//   apple_valid   out  apple position is final (render it, test for eating)
//   apple_eaten   out  1-cycle pulse on eat
//   grow          out  1-cycle pulse on eat, coincident with apple_eaten
//   score         out  saturating count of apples eaten
//   place_fail    out  sticky: a placement ran out of retries
// ----------------------------------------------------------------------------
module apple_placer #(
    parameter int LEN_W     = 8,
    parameter int SCORE_W   = 10,
    parameter int MAX_RETRY = 8
) (
    input  logic               clk_25M,
    input  logic               rst,
    input  logic               move_tick,
    input  logic [6:0]         head_x,
    input  logic [5:0]         head_y,
    input  logic [LEN_W-1:0]   snake_len,
    output logic [LEN_W-1:0]   body_rd_addr,
    input  logic [6:0]         body_x,
    input  logic [5:0]         body_y,
    input  logic [6:0]         apple_x_pos,
    input  logic [5:0]         apple_y_pos,
    output logic               apple_gen,
    output logic               apple_valid,
    output logic               apple_eaten,
    output logic               grow,
    output logic [SCORE_W-1:0] score,
    output logic               place_fail
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        WAIT,
        CHECK
    } state_t;

    state_t             state_q, state_d;
    logic               eat_q, eat_d;        // the one-cycle eat pulse
    logic [LEN_W-1:0]   len_q, len_d;        // snake_len frozen for the scan
    logic [LEN_W-1:0]   idx_q, idx_d;        // 0 = head compare, k = body[k-1]
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               fail_q, fail_d;

    logic head_hit;
    logic body_hit;
    logic cand_hit;

    // The same head comparator serves eat detection in IDLE and the
    // head-versus-candidate test on the first CHECK cycle.
    assign head_hit = (head_x == apple_x_pos) && (head_y == apple_y_pos);
    assign body_hit = (body_x == apple_x_pos) && (body_y == apple_y_pos);

    // Body RAM data lags the address by one cycle, so the compare at idx k
    // (k >= 1) looks at segment k-1; idx 0 has no body data yet and tests
    // the head instead.
    assign cand_hit = (idx_q == '0) ? head_hit : body_hit;

    // Reset parks the FSM in WAIT: every output is 0 there and the first
    // clock after release moves straight into CHECK, which validates the
    // generator's own reset apple.
    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
            eat_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            score_q <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            eat_q   <= eat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            score_q <= score_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        eat_d        = 1'b0;
        len_d        = len_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        score_d      = score_q;
        fail_d       = fail_q;
        apple_gen    = 1'b0;
        apple_valid  = 1'b0;
        body_rd_addr = '0;

        case (state_q)
            IDLE: begin
                // During the eat cycle the apple is no longer shown and a
                // second move_tick on the same spot must not count again.
                apple_valid = !eat_q;
                if (eat_q) begin
                    state_d = GEN;
                end else if (move_tick && head_hit) begin
                    eat_d   = 1'b1;
                    retry_d = '0;
                    if (score_q != '1) begin
                        score_d = score_q + 1'b1;
                    end
                end
            end

            GEN: begin
                apple_gen = 1'b1;
                state_d   = WAIT;
            end

            WAIT: begin
                // The generator has just updated; give it one cycle and
                // latch the snake length for the coming scan.
                state_d = CHECK;
                len_d   = snake_len;
                idx_d   = '0;
            end

            CHECK: begin
                // The final compare cycle has no further address to issue.
                if (idx_q < len_q) begin
                    body_rd_addr = idx_q;
                end
                if (cand_hit) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        state_d = GEN;
                    end else begin
                        // Out of retries: keep the overlapping candidate
                        // rather than stall the game.
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (idx_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = WAIT;
            end
        endcase
    end

    assign apple_eaten = eat_q;
    assign grow        = eat_q;
    assign score       = score_q;
    assign place_fail  = fail_q;

endmodule

// File: tb/tb_apple_placer.sv
`timescale 1ns/1ps
module tb_apple_placer;

    localparam int LEN_W     = 8;
    localparam int SCORE_W   = 10;
    localparam int MAX_RETRY = 8;
    localparam int BUDGET    = 400;

    logic               clk_25M   = 1'b0;
    logic               rst       = 1'b0;
    logic               move_tick = 1'b0;
    logic [6:0]         head_x    = '0;
    logic [5:0]         head_y    = '0;
    logic [LEN_W-1:0]   snake_len = '0;
    logic [LEN_W-1:0]   body_rd_addr;
    logic [6:0]         body_x;
    logic [5:0]         body_y;
    logic [6:0]         apple_x_pos;
    logic [5:0]         apple_y_pos;
    logic               apple_gen;
    logic               apple_valid;
    logic               apple_eaten;
    logic               grow;
    logic [SCORE_W-1:0] score;
    logic               place_fail;

    apple_placer #(
        .LEN_W    (LEN_W),
        .SCORE_W  (SCORE_W),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_25M     (clk_25M),
        .rst         (rst),
        .move_tick   (move_tick),
        .head_x      (head_x),
        .head_y      (head_y),
        .snake_len   (snake_len),
        .body_rd_addr(body_rd_addr),
        .body_x      (body_x),
        .body_y      (body_y),
        .apple_x_pos (apple_x_pos),
        .apple_y_pos (apple_y_pos),
        .apple_gen   (apple_gen),
        .apple_valid (apple_valid),
        .apple_eaten (apple_eaten),
        .grow        (grow),
        .score       (score),
        .place_fail  (place_fail)
    );

    always #20 clk_25M = ~clk_25M;

    // Body RAM model with registered read
    logic [6:0] bram_x [0:255];
    logic [5:0] bram_y [0:255];
    always @(posedge clk_25M) begin
        body_x <= bram_x[body_rd_addr];
        body_y <= bram_y[body_rd_addr];
    end

    // Apple generator model: scripted candidates, then random ones
    logic [6:0] cand_x [0:15];
    logic [5:0] cand_y [0:15];
    int gen_total = 0;
    int cand_base = 0;
    int cand_n    = 0;
    always @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            apple_x_pos <= 7'd75;
            apple_y_pos <= 6'd30;
        end else if (apple_gen) begin
            if (gen_total - cand_base < cand_n) begin
                apple_x_pos <= cand_x[4'(gen_total - cand_base)];
                apple_y_pos <= cand_y[4'(gen_total - cand_base)];
            end else begin
                apple_x_pos <= 7'($urandom_range(0, 79));
                apple_y_pos <= 6'($urandom_range(0, 59));
            end
            gen_total <= gen_total + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Observation results (written only by the main initial block)
    int obs_valid, obs_gens, obs_eats, obs_eat_at, obs_gen_at, obs_grow_bad;

    task automatic observe(input int hold);
        obs_valid = -1; obs_gens = 0; obs_eats = 0;
        obs_eat_at = -1; obs_gen_at = -1; obs_grow_bad = 0;
        for (int s = 1; s <= BUDGET; s++) begin
            @(negedge clk_25M);
            if (s == 1 + hold) move_tick = 1'b0;
            if (grow != apple_eaten) obs_grow_bad++;
            if (apple_gen) begin
                obs_gens++;
                if (obs_gen_at < 0) obs_gen_at = s;
            end
            if (apple_eaten) begin
                obs_eats++;
                if (obs_eat_at < 0) obs_eat_at = s;
            end
            if (apple_valid) begin
                obs_valid = s;
                break;
            end
        end
        move_tick = 1'b0;
    endtask

    // Called at a negedge while the apple is valid: step the head onto it.
    task automatic do_eat(input int hold);
        head_x    = apple_x_pos;
        head_y    = apple_y_pos;
        cand_base = gen_total;
        move_tick = 1'b1;
        observe(hold);
    endtask

    // Reference: each candidate costs 2 cycles (GEN+WAIT) plus its scan,
    // which stops at the first overlap (head = 1 cycle, body[j] = j+2) or
    // runs len+1 cycles. The first request comes 2 samples after move_tick.
    function automatic void model_place(input int slen, input logic [6:0] hx,
                                        input logic [5:0] hy, output int gens,
                                        output int valid_at, output int failed);
        int  t;
        int  cost;
        bit  hit;
        t = 2; gens = 0; failed = 0;
        for (int k = 0; k <= MAX_RETRY; k++) begin
            gens++;
            hit  = 1'b0;
            cost = slen + 1;
            if (cand_x[k] == hx && cand_y[k] == hy) begin
                hit = 1'b1; cost = 1;
            end else begin
                for (int j = slen - 1; j >= 0; j--) begin
                    if (bram_x[j] == cand_x[k] && bram_y[j] == cand_y[k]) begin
                        hit = 1'b1; cost = j + 2;
                    end
                end
            end
            t = t + 2 + cost;
            if (!hit) break;
            if (k == MAX_RETRY) failed = 1;
        end
        valid_at = t;
    endfunction

    typedef struct {
        int slen;
        int n_bad;
        int bad_seg;   // -1: bad candidates sit on the head
        int hold;      // keep move_tick high through the eat cycle
        int exp_gens;
        int exp_valid;
        int exp_fail;
        int exp_score;
    } vec_t;

    vec_t vecs [0:5];
    int   score_m;
    int   fail_m;
    int   e_gens, e_valid, e_fail;
    int   found;
    logic [6:0] hx0;
    logic [5:0] hy0;

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, 0,  0, 0, 1,  8, 0, 1};
        vecs[1] = '{3, 1,  2, 0, 2, 14, 0, 2};
        vecs[2] = '{5, 2,  0, 1, 3, 18, 0, 3};
        vecs[3] = '{0, 0,  0, 0, 1,  5, 0, 4};
        vecs[4] = '{6, 1, -1, 1, 2, 14, 0, 5};
        vecs[5] = '{4, 9,  3, 0, 9, 65, 1, 6};

        for (int k = 0; k < 256; k++) begin
            bram_x[k] = 7'(10 + (k % 60));
            bram_y[k] = 6'd5;
        end

        // ---- reset state and validation of the reset apple ----
        rst = 1'b0; snake_len = 8'd3; head_x = 7'd0; head_y = 6'd0;
        repeat (3) @(negedge clk_25M);
        chk("rst_valid", int'(apple_valid), 0);
        chk("rst_gen",   int'(apple_gen),   0);
        chk("rst_eaten", int'(apple_eaten), 0);
        chk("rst_grow",  int'(grow),        0);
        chk("rst_score", int'(score),       0);
        chk("rst_fail",  int'(place_fail),  0);
        chk("rst_addr",  int'(body_rd_addr), 0);
        rst = 1'b1;
        observe(0);
        chk("boot_valid_at", obs_valid, 5);
        chk("boot_gens",     obs_gens,  0);
        chk("boot_score",    int'(score), 0);
        $display("boot: valid_at=%0d gens=%0d", obs_valid, obs_gens);

        // ---- table-driven placements ----
        for (int i = 0; i < 6; i++) begin
            snake_len = 8'(vecs[i].slen);
            for (int k = 0; k < vecs[i].n_bad; k++) begin
                if (vecs[i].bad_seg < 0) begin
                    cand_x[k] = apple_x_pos; cand_y[k] = apple_y_pos;
                end else begin
                    cand_x[k] = bram_x[vecs[i].bad_seg];
                    cand_y[k] = bram_y[vecs[i].bad_seg];
                end
            end
            cand_x[vecs[i].n_bad] = 7'(60 + i);
            cand_y[vecs[i].n_bad] = 6'd40;
            cand_n = vecs[i].n_bad + 1;
            do_eat(vecs[i].hold);
            chk("tbl_eat_at",   obs_eat_at,   1);
            chk("tbl_eats",     obs_eats,     1);
            chk("tbl_grow",     obs_grow_bad, 0);
            chk("tbl_gen_at",   obs_gen_at,   2);
            chk("tbl_gens",     obs_gens,     vecs[i].exp_gens);
            chk("tbl_valid_at", obs_valid,    vecs[i].exp_valid);
            chk("tbl_score",    int'(score),  vecs[i].exp_score);
            chk("tbl_fail",     int'(place_fail), vecs[i].exp_fail);
            $display("vec %0d: len=%0d gens=%0d valid_at=%0d score=%0d fail=%0d",
                     i, vecs[i].slen, obs_gens, obs_valid, score, place_fail);
        end

        // ---- randomized placements against the reference ----
        score_m = 6; fail_m = 1;
        for (int it = 0; it < 20; it++) begin
            snake_len = 8'($urandom_range(0, 10));
            for (int j = 0; j < int'(snake_len); j++) begin
                bram_x[j] = 7'($urandom_range(0, 5));
                bram_y[j] = 6'($urandom_range(0, 3));
            end
            for (int k = 0; k <= MAX_RETRY; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    cand_x[k] = 7'($urandom_range(0, 5));
                    cand_y[k] = 6'($urandom_range(0, 3));
                end else begin
                    cand_x[k] = 7'($urandom_range(20, 79));
                    cand_y[k] = 6'($urandom_range(10, 59));
                end
            end
            cand_n = MAX_RETRY + 1;
            hx0 = apple_x_pos; hy0 = apple_y_pos;
            model_place(int'(snake_len), hx0, hy0, e_gens, e_valid, e_fail);
            if (e_fail != 0) fail_m = 1;
            if (score_m < 1023) score_m++;
            do_eat(int'($urandom_range(0, 1)));
            chk("rnd_eats",     obs_eats,  1);
            chk("rnd_gens",     obs_gens,  e_gens);
            chk("rnd_valid_at", obs_valid, e_valid);
            chk("rnd_score",    int'(score), score_m);
            chk("rnd_fail",     int'(place_fail), fail_m);
            $display("rnd %0d: len=%0d gens=%0d valid_at=%0d score=%0d",
                     it, snake_len, obs_gens, obs_valid, score);
        end

        // ---- score saturation ----
        snake_len = 8'd0; cand_n = 0;
        while (score_m < 1023) begin
            do_eat(0);
            score_m++;
            if (obs_valid < 0) begin
                chk("sat_fill_timeout", obs_valid, 0);
                break;
            end
        end
        chk("sat_reach", int'(score), 1023);
        for (int k = 0; k < 3; k++) begin
            do_eat(0);
            chk("sat_eats",  obs_eats,    1);
            chk("sat_score", int'(score), 1023);
            $display("sat %0d: eats=%0d score=%0d", k, obs_eats, score);
        end

        // ---- reset in the middle of a CHECK scan ----
        for (int k = 0; k < 256; k++) begin
            bram_x[k] = 7'(10 + (k % 60));
            bram_y[k] = 6'd5;
        end
        snake_len = 8'd8;
        cand_x[0] = 7'd70; cand_y[0] = 6'd50; cand_n = 1;
        head_x = apple_x_pos; head_y = apple_y_pos;
        cand_base = gen_total;
        move_tick = 1'b1;
        @(negedge clk_25M);
        move_tick = 1'b0;
        found = 0;
        for (int s = 0; s < 60; s++) begin
            @(negedge clk_25M);
            if (body_rd_addr == 8'd4) begin
                found = 1;
                break;
            end
        end
        chk("mid_addr4_seen", found, 1);
        rst = 1'b0;
        head_x = 7'd0; head_y = 6'd0;
        #1;
        chk("mid_rst_valid", int'(apple_valid), 0);
        chk("mid_rst_gen",   int'(apple_gen),   0);
        chk("mid_rst_eaten", int'(apple_eaten), 0);
        chk("mid_rst_score", int'(score),       0);
        chk("mid_rst_fail",  int'(place_fail),  0);
        chk("mid_rst_addr",  int'(body_rd_addr), 0);
        @(negedge clk_25M);
        rst = 1'b1;
        @(negedge clk_25M);
        chk("mid_restart_addr0", int'(body_rd_addr), 0);
        chk("mid_restart_valid", int'(apple_valid),  0);
        @(negedge clk_25M);
        chk("mid_restart_addr1", int'(body_rd_addr), 1);
        observe(0);
        chk("mid_valid_at", obs_valid, 8);
        chk("mid_gens",     obs_gens,  0);
        $display("mid-scan reset: valid_at=%0d gens=%0d score=%0d", obs_valid, obs_gens, score);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
